// File: rtl/clock_pkg.sv
// Shared types and sizing helpers for the alarm ring sequencer.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE
  } state_t;

  function automatic int tmr_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Tick-gated up-counter with sync clear; saturates at the terminal count.
module sec_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_last,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  assign o_tc = (r_cnt == i_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Turns the alarm match level into one ring episode with
// 1 s on/off buzzer, bounded snoozes, timeout and missed flag.
module alarm_ring_ctrl
  import clock_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sec_tick,
  input  logic al_match,
  input  logic al_enable,
  input  logic snooze_btn,
  input  logic stop_btn,
  output logic buzzer,
  output logic ringing,
  output logic snoozing,
  output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_cnt,
  output logic missed
);

  localparam int CW = $clog2(MAX_SNOOZE + 1);
  localparam int TW = tmr_w(RING_SECS, SNOOZE_SECS);
  localparam logic [CW-1:0] MAXC = CW'(MAX_SNOOZE);
  localparam logic [TW-1:0] RING_LAST = TW'(RING_SECS - 1);
  localparam logic [TW-1:0] SNZ_LAST = TW'(SNOOZE_SECS - 1);

  state_t        r_state;
  logic          r_match_q;
  logic          r_buzzer;
  logic          r_ringing;
  logic          r_snoozing;
  logic          r_missed;
  logic [CW-1:0] r_cnt;

  logic          w_trig;
  logic          w_tc;
  logic          w_clr;
  logic          w_inc;
  logic [TW-1:0] w_last;

  assign w_trig = al_match & ~r_match_q & al_enable;
  assign w_last = (r_state == SNOOZE) ? SNZ_LAST : RING_LAST;

  assign buzzer     = r_buzzer;
  assign ringing    = r_ringing;
  assign snoozing   = r_snoozing;
  assign snooze_cnt = r_cnt;
  assign missed     = r_missed;

  sec_timer #(
    .W(TW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_inc (w_inc),
    .i_last(w_last),
    .o_tc  (w_tc)
  );

  // Timer restarts on every state change and is held at 0 in IDLE.
  always_comb begin
    w_clr = 1'b0;
    w_inc = 1'b0;
    if (!al_enable) begin
      w_clr = 1'b1;
    end else begin
      unique case (r_state)
        RING: begin
          if (stop_btn) begin
            w_clr = 1'b1;
          end else if (snooze_btn) begin
            w_clr = (r_cnt < MAXC);
          end else if (sec_tick) begin
            w_clr = w_tc;
            w_inc = ~w_tc;
          end
        end
        SNOOZE: begin
          if (stop_btn) begin
            w_clr = 1'b1;
          end else if (sec_tick) begin
            w_clr = w_tc;
            w_inc = ~w_tc;
          end
        end
        default: w_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_match_q  <= 1'b0;
      r_buzzer   <= 1'b0;
      r_ringing  <= 1'b0;
      r_snoozing <= 1'b0;
      r_missed   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_match_q <= al_match;
      if (!al_enable) begin
        r_state    <= IDLE;
        r_buzzer   <= 1'b0;
        r_ringing  <= 1'b0;
        r_snoozing <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (stop_btn) r_missed <= 1'b0;
            if (w_trig) begin
              r_state   <= RING;
              r_buzzer  <= 1'b1;
              r_ringing <= 1'b1;
              r_cnt     <= '0;
            end
          end
          RING: begin
            if (stop_btn) begin
              r_state   <= IDLE;
              r_missed  <= 1'b0;
              r_buzzer  <= 1'b0;
              r_ringing <= 1'b0;
            end else if (snooze_btn) begin
              if (r_cnt < MAXC) begin
                r_state    <= SNOOZE;
                r_cnt      <= r_cnt + 1'b1;
                r_buzzer   <= 1'b0;
                r_ringing  <= 1'b0;
                r_snoozing <= 1'b1;
              end
            end else if (sec_tick) begin
              if (w_tc) begin
                r_state   <= IDLE;
                r_missed  <= 1'b1;
                r_buzzer  <= 1'b0;
                r_ringing <= 1'b0;
              end else begin
                r_buzzer <= ~r_buzzer;
              end
            end
          end
          SNOOZE: begin
            if (stop_btn) begin
              r_state    <= IDLE;
              r_snoozing <= 1'b0;
            end else if (sec_tick && w_tc) begin
              r_state    <= RING;
              r_buzzer   <= 1'b1;
              r_ringing  <= 1'b1;
              r_snoozing <= 1'b0;
            end
          end
          default: begin
            r_state    <= IDLE;
            r_buzzer   <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
